// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder/subtractor. A single 1-bit full-adder cell is stepped over
// the operand words LSB first, one bit per clock, with the carry held in a
// register between bits. The block offers a start/busy/done handshake.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   start      - operation request, only looked at while idle
//   sub        - 0: a+b, 1: a-b (b inverted, carry-in 1), captured with start
//   a, b       - operands, captured with start
//   busy       - high while an operation is in progress (RUN and DONE)
//   done       - one-cycle pulse when sum/carry_out/overflow become valid
//   sum        - result word, held until the next operation completes
//   carry_out  - raw carry out of the MSB cell (1 in sub mode = no borrow)
//   overflow   - signed overflow: carry into MSB xor carry out of MSB
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0] a_sh_reg;
   logic [WIDTH-1:0] b_sh_reg;
   logic [WIDTH-1:0] res_sh_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             carry_reg;
   logic             cin_msb_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_out_reg;
   logic             overflow_reg;
   logic             done_reg;

   logic cell_sum;
   logic cell_carry;
   logic last_bit;

   // The one and only adder cell, fed from the bottom of the shift registers.
   assign cell_sum   = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
   assign cell_carry = (a_sh_reg[0] & b_sh_reg[0]) |
                       (carry_reg & (a_sh_reg[0] ^ b_sh_reg[0]));

   assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Unused encodings fall back to IDLE so the FSM can never lock up.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start)    state_next = ST_RUN;
         ST_RUN:  if (last_bit) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_reg      <= '0;
         b_sh_reg      <= '0;
         res_sh_reg    <= '0;
         cnt_reg       <= '0;
         carry_reg     <= 1'b0;
         cin_msb_reg   <= 1'b0;
         sum_reg       <= '0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  a_sh_reg   <= a;
                  // Subtraction is a + ~b + 1: invert b now, seed carry with 1.
                  b_sh_reg   <= sub ? ~b : b;
                  carry_reg  <= sub;
                  cnt_reg    <= '0;
                  res_sh_reg <= '0;
               end
            end
            ST_RUN: begin
               a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
               b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
               // Result fills from the top, so after WIDTH shifts bit 0 is
               // the first sum bit computed.
               res_sh_reg <= {cell_sum, res_sh_reg[WIDTH-1:1]};
               carry_reg  <= cell_carry;
               cnt_reg    <= cnt_reg + CNT_W'(1);
               // On the MSB step the carry register is the carry into the MSB.
               if (last_bit) begin
                  cin_msb_reg <= carry_reg;
               end
            end
            ST_DONE: begin
               // carry_reg now holds the carry out of the MSB cell.
               sum_reg       <= res_sh_reg;
               carry_out_reg <= carry_reg;
               overflow_reg  <= cin_msb_reg ^ carry_reg;
               done_reg      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_reg != ST_IDLE);
   assign done      = done_reg;
   assign sum       = sum_reg;
   assign carry_out = carry_out_reg;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl (WIDTH=16). Each operation is launched,
// observed on the falling edge after every rising edge, and its busy length,
// done timing, and result flags are compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
   logic             overflow;

   int checks   = 0;
   int failures = 0;
   logic [WIDTH-1:0] last_sum;

   serial_add_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Launch one op at a falling edge, then watch the falling edge after each
   // of the following rising edges (k = 0 is just after the accepting edge).
   // With inject set, a second start with other operands is pulsed mid-RUN.
   task automatic run_op(input string tag,
                         input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vsub,
                         input logic [WIDTH-1:0] exp_sum,
                         input logic exp_co, input logic exp_ov,
                         input bit inject);
      int busy_n;
      int done_n;
      int done_at;
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      a     = va;
      b     = vb;
      sub   = vsub;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < WIDTH + 4; k++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_at < 0) done_at = k;
         end
         if (k == 8) check({tag, "_sum_hold"}, 32'(sum), 32'(last_sum));
         if (inject && k == 5) begin
            a = 16'h1111; b = 16'h2222; sub = 1'b1; start = 1'b1;
         end
         if (inject && k == 7) start = 1'b0;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 32'(busy_n), 32'(WIDTH + 1));
      check({tag, "_done_edge"},   32'(done_at), 32'(WIDTH + 1));
      check({tag, "_done_count"},  32'(done_n), 32'd1);
      check({tag, "_sum"},         32'(sum), 32'(exp_sum));
      check({tag, "_carry_out"},   32'(carry_out), 32'(exp_co));
      check({tag, "_overflow"},    32'(overflow), 32'(exp_ov));
      $display("op %s a=0x%04h b=0x%04h sub=%0d -> sum=0x%04h co=%0d ov=%0d",
               tag, va, vb, vsub, sum, carry_out, overflow);
      last_sum = exp_sum;
   endtask

   initial begin
      int done_n;
      int first_done;
      int second_done;
      int busy_low;

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      last_sum = '0;
      repeat (3) @(negedge clk);
      check("rst_busy",  32'(busy), 32'd0);
      check("rst_done",  32'(done), 32'd0);
      check("rst_sum",   32'(sum), 32'd0);
      check("rst_co",    32'(carry_out), 32'd0);
      check("rst_ov",    32'(overflow), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add3p5",   16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
      run_op("addwrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      run_op("addovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      run_op("sub5m3",   16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
      run_op("sub3m5",   16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      run_op("subovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      run_op("ignstart", 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b1);

      // Abort an op with a live carry chain by an asynchronous reset mid-RUN.
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_sum",  32'(sum), 32'd0);
      check("arst_co",   32'(carry_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      last_sum = '0;
      @(negedge clk);
      run_op("postrst",  16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);

      // start held high: back-to-back ops, one idle cycle between them.
      done_n = 0; first_done = -1; second_done = -1; busy_low = 0;
      a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 40; k++) begin
         if (!busy) busy_low++;
         if (done) begin
            done_n++;
            if (first_done < 0) first_done = k;
            else if (second_done < 0) second_done = k;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("hold_done_count",  32'(done_n), 32'd2);
      check("hold_first_done",  32'(first_done), 32'd17);
      check("hold_second_done", 32'(second_done), 32'd35);
      check("hold_busy_low",    32'(busy_low), 32'd2);
      check("hold_sum",         32'(sum), 32'h0002);
      $display("op hold a=0x0001 b=0x0001 -> done at %0d and %0d, sum=0x%04h",
               first_done, second_done, sum);
      repeat (WIDTH + 4) @(negedge clk);
      check("hold_final_idle",  32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
